vec_mem_seq: RTL

- Vector load/store sequencer between the CVP14 control path and the DRAM port.
- On a single start pulse, it moves a full VLEN-element vector between consecutive DRAM halfwords and one vector register.
- It generates the DRAM address and RD/WR strobes itself, and drives the vector register file's element write/read ports one element at a time.

---
 rtl/cvp14_pkg.sv | 20 ++
 rtl/vec_mem_seq_if.sv | 46 ++++
 rtl/vls_addr_gen.sv | 49 ++++
 rtl/vec_mem_seq.sv | 122 ++++++++++++
 4 files changed

// File: rtl/cvp14_pkg.sv
// Shared CVP14 constants, vector load/store state encoding and op codes.
package cvp14_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int VLEN   = 16;
    localparam int NVEC   = 8;
    localparam int VIDX_W = $clog2(NVEC);
    localparam int ELEM_W = $clog2(VLEN);

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        ST_WR,
        DONE
    } vls_state_t;

    localparam logic OP_VLD = 1'b0;
    localparam logic OP_VST = 1'b1;
endpackage

// File: rtl/vec_mem_seq_if.sv
// Control, DRAM and vector-register-file signals of the vector load/store sequencer.
// Optional VLS_STRIDE_EN adds the Stride request field.
interface vec_mem_seq_if;
    import cvp14_pkg::*;

    logic              Start;
    logic              Op;
    logic [ADDR_W-1:0] BaseAddr;
    logic [VIDX_W-1:0] VecSel;
`ifdef VLS_STRIDE_EN
    logic [ADDR_W-1:0] Stride;
`endif
    logic              Busy;
    logic              Done;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemRD;
    logic              MemWR;
    logic [DATA_W-1:0] MemDataOut;
    logic [DATA_W-1:0] MemDataIn;
    logic              VWrEn;
    logic [VIDX_W-1:0] VWrIdx;
    logic [ELEM_W-1:0] VWrElem;
    logic [DATA_W-1:0] VWrData;
    logic [VIDX_W-1:0] VRdIdx;
    logic [ELEM_W-1:0] VRdElem;
    logic [DATA_W-1:0] VRdData;

    // slave: the sequencer itself; master: control path, DRAM and register file
    modport slave (
`ifdef VLS_STRIDE_EN
        input  Stride,
`endif
        input  Start, Op, BaseAddr, VecSel, MemDataIn, VRdData,
        output Busy, Done, MemAddr, MemRD, MemWR, MemDataOut,
        output VWrEn, VWrIdx, VWrElem, VWrData, VRdIdx, VRdElem
    );

    modport master (
`ifdef VLS_STRIDE_EN
        output Stride,
`endif
        output Start, Op, BaseAddr, VecSel, MemDataIn, VRdData,
        input  Busy, Done, MemAddr, MemRD, MemWR, MemDataOut,
        input  VWrEn, VWrIdx, VWrElem, VWrData, VRdIdx, VRdElem
    );
endinterface

// File: rtl/vls_addr_gen.sv
// Element counter and DRAM address accumulator for one vector transfer.
module vls_addr_gen
    import cvp14_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    output logic [ADDR_W-1:0] addr,
    output logic [ELEM_W-1:0] elem,
    output logic              last
);
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ELEM_W-1:0] elem_q, elem_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            stride_q <= '0;
            elem_q   <= '0;
        end else begin
            addr_q   <= addr_d;
            stride_q <= stride_d;
            elem_q   <= elem_d;
        end
    end

    // Address wraps modulo 2^ADDR_W by plain overflow of the accumulator.
    always_comb begin
        addr_d   = addr_q;
        stride_d = stride_q;
        elem_d   = elem_q;
        if (load) begin
            addr_d   = base;
            stride_d = stride;
            elem_d   = '0;
        end else if (step) begin
            addr_d = addr_q + stride_q;
            elem_d = elem_q + ELEM_W'(1);
        end
    end

    assign addr = addr_q;
    assign elem = elem_q;
    assign last = (elem_q == ELEM_W'(VLEN - 1));
endmodule

// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer: moves one VLEN-element vector between DRAM and a vector register.
// Optional VLS_STRIDE_EN: element addresses step by bus.Stride instead of 1.
module vec_mem_seq
    import cvp14_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic         Clk1,
    input  logic         Reset,
    vec_mem_seq_if.slave bus
);
    // state   | meaning
    // IDLE    | waiting for Start
    // LD_REQ  | MemRD issued for element i
    // LD_WAIT | read latency; element written to VRF in the last wait cycle
    // ST_WR   | element i read from VRF and written to DRAM
    // DONE    | one-cycle completion pulse

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    vls_state_t        state_q, state_d;
    logic [VIDX_W-1:0] vec_q, vec_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              ag_load, ag_step, ag_last;
    logic [ADDR_W-1:0] ag_addr, stride;
    logic [ELEM_W-1:0] ag_elem;

`ifdef VLS_STRIDE_EN
    assign stride = bus.Stride;
`else
    assign stride = ADDR_W'(1);
`endif

    vls_addr_gen u_addr_gen (
        .clk    (Clk1),
        .rst    (Reset),
        .load   (ag_load),
        .step   (ag_step),
        .base   (bus.BaseAddr),
        .stride (stride),
        .addr   (ag_addr),
        .elem   (ag_elem),
        .last   (ag_last)
    );

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state_q <= IDLE;
            vec_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        vec_d          = vec_q;
        lat_d          = lat_q;
        ag_load        = 1'b0;
        ag_step        = 1'b0;
        bus.Busy       = 1'b0;
        bus.Done       = 1'b0;
        bus.MemAddr    = '0;
        bus.MemRD      = 1'b0;
        bus.MemWR      = 1'b0;
        bus.MemDataOut = '0;
        bus.VWrEn      = 1'b0;
        bus.VWrIdx     = '0;
        bus.VWrElem    = '0;
        bus.VWrData    = '0;
        bus.VRdIdx     = '0;
        bus.VRdElem    = '0;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    ag_load = 1'b1;
                    vec_d   = bus.VecSel;
                    state_d = (bus.Op == OP_VST) ? ST_WR : LD_REQ;
                end
            end
            LD_REQ: begin
                bus.Busy    = 1'b1;
                bus.MemRD   = 1'b1;
                bus.MemAddr = ag_addr;
                lat_d       = LAT_W'(RD_LAT - 1);
                state_d     = LD_WAIT;
            end
            LD_WAIT: begin
                bus.Busy    = 1'b1;
                bus.MemAddr = ag_addr;
                if (lat_q == '0) begin
                    bus.VWrEn   = 1'b1;
                    bus.VWrIdx  = vec_q;
                    bus.VWrElem = ag_elem;
                    bus.VWrData = bus.MemDataIn;
                    ag_step     = 1'b1;
                    state_d     = ag_last ? DONE : LD_REQ;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_WR: begin
                bus.Busy       = 1'b1;
                bus.VRdIdx     = vec_q;
                bus.VRdElem    = ag_elem;
                bus.MemWR      = 1'b1;
                bus.MemAddr    = ag_addr;
                bus.MemDataOut = bus.VRdData;
                ag_step        = 1'b1;
                state_d        = ag_last ? DONE : ST_WR;
            end
            DONE: begin
                bus.Done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
